// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and helpers for the register-file slave.
// Response encodings and strobe-width helper.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Byte-strobed register storage with one write and one read port.
// reg_out exposes every register directly to control logic.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 8,
  parameter int          IDX_W     = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam int STRB_W = strb_width(DATA_W);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && wr_idx == IDX_W'(i)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) begin
            regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave over a bank of memory-mapped registers.
// AW and W are held independently; the write commits once both are held.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int OFF_W  = $clog2(STRB_W);

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

  logic [ADDR_W-1:0] aw_idx;
  logic [ADDR_W-1:0] ar_idx;
  logic              aw_ok;
  logic              ar_ok;
  logic              commit;
  logic              we;
  logic [DATA_W-1:0] rd_data;

  function automatic logic idx_ok(
    input logic [ADDR_W-1:0] idx
  );
    return 32'(idx) < NUM_REGS;
  endfunction

  assign aw_idx = aw_addr_q >> OFF_W;
  assign ar_idx = ARADDR >> OFF_W;
  assign aw_ok  = idx_ok(aw_idx);
  assign ar_ok  = idx_ok(ar_idx);
  assign commit = aw_held_q && w_held_q;
  assign we     = commit && aw_ok;

  assign AWREADY = !aw_held_q && !bvalid_q;
  assign WREADY  = !w_held_q && !bvalid_q;
  assign ARREADY = !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (AWVALID && AWREADY) begin
      aw_held_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && WREADY) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? OKAY : SLVERR;
    end
    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
      bresp_d  = OKAY;
    end
  end

  // Bank read is combinational, so a same-edge commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ARVALID && ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? rd_data : '0;
      rresp_d  = ar_ok ? OKAY : SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_lite_reg_bank #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (ADDR_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .we      (we),
    .wr_idx  (aw_idx),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q),
    .rd_idx  (ar_idx),
    .rd_data (rd_data),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Scoreboard bench for the AXI4-Lite register-file slave.
// Expected responses are queued at stimulus time and popped on B/R.
module tb_axi_lite_regfile_slave;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b1;
  logic [NR*DW-1:0] reg_out;

  axi_lite_regfile_slave #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .NUM_REGS  (NR),
    .RESET_VAL ('0)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .reg_out (reg_out)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  logic [1:0]    exp_b[$];
  logic [DW-1:0] exp_rd[$];
  logic [1:0]    exp_rr[$];
  logic [DW-1:0] model [NR];

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a,
                             input logic [DW-1:0] d,
                             input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < NR) begin
      exp_rd.push_back(model[idx]);
      exp_rr.push_back(2'b00);
    end else begin
      exp_rd.push_back('0);
      exp_rr.push_back(2'b10);
    end
  endtask

  task automatic drive_write(input logic [AW-1:0] a,
                             input logic [DW-1:0] d,
                             input logic [3:0] s,
                             output bit to);
    bit aw_done, w_done, awr, wr;
    int n;
    model_write(a, d, s);
    AWADDR = a; AWVALID = 1'b1;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      awr = AWREADY; wr = WREADY;
      tick(); n++;
      if (AWVALID && awr) begin aw_done = 1; AWVALID = 1'b0; end
      if (WVALID && wr) begin w_done = 1; WVALID = 1'b0; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    to = !(aw_done && w_done);
  endtask

  task automatic wait_b(output logic [1:0] r, output int lat,
                        output bit to);
    lat = 0;
    while (!BVALID && lat < 20) begin tick(); lat++; end
    to = !BVALID;
    r = BRESP;
    if (BVALID && BREADY) tick();
  endtask

  task automatic drive_read(input logic [AW-1:0] a, output bit to);
    bit rdy, done;
    int n;
    model_read(a);
    ARADDR = a; ARVALID = 1'b1;
    done = 0; n = 0;
    while (!done && n < 20) begin
      rdy = ARREADY;
      tick(); n++;
      if (rdy) done = 1;
    end
    ARVALID = 1'b0;
    to = !done;
  endtask

  task automatic wait_r(output logic [DW-1:0] d, output logic [1:0] r,
                        output bit to);
    int n;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    to = !RVALID;
    d = RDATA; r = RRESP;
    if (RVALID && RREADY) tick();
  endtask

  task automatic test_reset();
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: bvalid=%b rvalid=%b want 0 0",
               BVALID, RVALID);
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== '0) begin
      failures++;
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h want 0",
               BRESP, RRESP, RDATA);
    end
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: aw/w/ar=%b%b%b want 111",
               AWREADY, WREADY, ARREADY);
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL reset_regs: got %h want %h", reg_out, flat());
    end
  endtask

  task automatic test_same_cycle();
    bit to; int lat; logic [1:0] r, eb;
    drive_write(8'h08, 32'hDEADBEEF, 4'hF, to);
    checks++;
    if (to || BVALID !== 1'b0) begin
      failures++;
      $display("FAIL sc_hs: timeout=%b bvalid=%b want 0 0", to, BVALID);
    end
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || lat != 1) begin
      failures++;
      $display("FAIL sc_b_latency: got %0d want 1", lat);
    end
    checks++;
    if (r !== eb) begin
      failures++;
      $display("FAIL sc_bresp: got %b want %b", r, eb);
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL sc_regs: got %h want %h", reg_out, flat());
    end
  endtask

  task automatic test_w_first();
    bit to; int lat; logic [1:0] r, eb;
    model_write(8'h04, 32'hA5A50001, 4'hF);
    WDATA = 32'hA5A50001; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin
        failures++;
        $display("FAIL wf_hold: wready=%b awready=%b bvalid=%b want 0 1 0",
                 WREADY, AWREADY, BVALID);
      end
      tick();
    end
    AWADDR = 8'h04; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || lat != 1 || r !== eb) begin
      failures++;
      $display("FAIL wf_b: lat=%0d resp=%b want 1 %b", lat, r, eb);
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL wf_regs: got %h want %h", reg_out, flat());
    end
  endtask

  task automatic test_strobe();
    bit to; int lat; logic [1:0] r, eb, er; logic [DW-1:0] d, ed;
    drive_write(8'h08, 32'h12345678, 4'h3, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || r !== eb) begin
      failures++;
      $display("FAIL st_bresp: got %b want %b", r, eb);
    end
    checks++;
    if (reg_out[2*DW +: DW] !== 32'hDEAD5678) begin
      failures++;
      $display("FAIL st_reg2: got %h want deaf5678-merge %h",
               reg_out[2*DW +: DW], 32'hDEAD5678);
    end
    foreach (exp_rd[i]) ;
    drive_read(8'h08, to);
    checks++;
    if (to || RVALID !== 1'b1) begin
      failures++;
      $display("FAIL st_r_latency: rvalid=%b want 1", RVALID);
    end
    wait_r(d, r, to);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    checks++;
    if (d !== ed || r !== er) begin
      failures++;
      $display("FAIL st_read: got %h/%b want %h/%b", d, r, ed, er);
    end
    drive_read(8'h0B, to);
    wait_r(d, r, to);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    checks++;
    if (to || d !== ed || r !== er) begin
      failures++;
      $display("FAIL st_offset_read: got %h/%b want %h/%b", d, r, ed, er);
    end
  endtask

  task automatic test_out_of_range();
    bit to; int lat; logic [1:0] r, eb, er; logic [DW-1:0] d, ed;
    logic [AW-1:0] rd_addrs [3];
    drive_write(8'h20, 32'hFFFFFFFF, 4'hF, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || r !== eb) begin
      failures++;
      $display("FAIL oor_bresp: got %b want %b", r, eb);
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL oor_regs: got %h want %h", reg_out, flat());
    end
    drive_write(8'h1C, 32'h11223344, 4'h8, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || r !== eb || reg_out !== flat()) begin
      failures++;
      $display("FAIL top_reg_write: resp=%b want %b regs %h want %h",
               r, eb, reg_out, flat());
    end
    rd_addrs[0] = 8'h20; rd_addrs[1] = 8'h1C; rd_addrs[2] = 8'hFC;
    for (int k = 0; k < 3; k++) begin
      drive_read(rd_addrs[k], to);
      wait_r(d, r, to);
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      checks++;
      if (to || d !== ed || r !== er) begin
        failures++;
        $display("FAIL oor_read_%h: got %h/%b want %h/%b",
                 rd_addrs[k], d, r, ed, er);
      end
    end
  endtask

  task automatic test_b_backpressure();
    bit to; int lat; logic [1:0] r, eb;
    BREADY = 1'b0;
    drive_write(8'h0C, 32'hCAFE0003, 4'hF, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || r !== eb) begin
      failures++;
      $display("FAIL bp_first_b: got %b want %b", r, eb);
    end
    AWADDR = 8'h10; AWVALID = 1'b1;
    WDATA = 32'h0000BEE4; WSTRB = 4'hF; WVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (BVALID !== 1'b1 || BRESP !== eb ||
          AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall: bv=%b br=%b awr=%b wr=%b want 1 %b 0 0",
                 BVALID, BRESP, AWREADY, WREADY, eb);
      end
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL bp_no_write: got %h want %h", reg_out, flat());
    end
    BREADY = 1'b1;
    tick();
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: bv=%b awr=%b wr=%b want 0 1 1",
               BVALID, AWREADY, WREADY);
    end
    model_write(8'h10, 32'h0000BEE4, 4'hF);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || lat != 1 || r !== eb || reg_out !== flat()) begin
      failures++;
      $display("FAIL bp_second: lat=%0d resp=%b regs %h want 1 %b %h",
               lat, r, reg_out, eb, flat());
    end
  endtask

  task automatic test_r_backpressure();
    bit to; int lat; logic [1:0] r, eb, er; logic [DW-1:0] ed;
    RREADY = 1'b0;
    drive_read(8'h0C, to);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    checks++;
    if (to || RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
      failures++;
      $display("FAIL rbp_first: rv=%b rd=%h rr=%b want 1 %h %b",
               RVALID, RDATA, RRESP, ed, er);
    end
    drive_write(8'h0C, 32'h0BADF00D, 4'hF, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    checks++;
    if (to || r !== eb) begin
      failures++;
      $display("FAIL rbp_write_b: got %b want %b", r, eb);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (RVALID !== 1'b1 || ARREADY !== 1'b0 ||
          RDATA !== ed || RRESP !== er) begin
        failures++;
        $display("FAIL rbp_stall: rv=%b arr=%b rd=%h want 1 0 %h",
                 RVALID, ARREADY, RDATA, ed);
      end
    end
    RREADY = 1'b1;
    tick();
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL rbp_release: rv=%b arr=%b want 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_simultaneous();
    bit to; int lat; logic [1:0] r, eb, er; logic [DW-1:0] ed;
    drive_write(8'h14, 32'h55555555, 4'hF, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    model_read(8'h14);
    model_write(8'h14, 32'hAAAA0000, 4'hF);
    AWADDR = 8'h14; AWVALID = 1'b1;
    WDATA = 32'hAAAA0000; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h14; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    eb = exp_b.pop_front();
    checks++;
    if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
      failures++;
      $display("FAIL sim_read_old: rv=%b rd=%h want 1 %h",
               RVALID, RDATA, ed);
    end
    checks++;
    if (BVALID !== 1'b1 || BRESP !== eb || reg_out !== flat()) begin
      failures++;
      $display("FAIL sim_commit: bv=%b br=%b regs %h want 1 %b %h",
               BVALID, BRESP, reg_out, eb, flat());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit to; int lat; logic [1:0] r, eb, er; logic [DW-1:0] d, ed;
    BREADY = 1'b0; RREADY = 1'b0;
    drive_write(8'h18, 32'h66666666, 4'hF, to);
    wait_b(r, lat, to);
    eb = exp_b.pop_front();
    drive_read(8'h18, to);
    wait_r(d, r, to);
    ed = exp_rd.pop_front(); er = exp_rr.pop_front();
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1 || d !== ed) begin
      failures++;
      $display("FAIL rm_pending: bv=%b rv=%b rd=%h want 1 1 %h",
               BVALID, RVALID, d, ed);
    end
    #3 ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
      failures++;
      $display("FAIL rm_async_drop: bv=%b rv=%b want 0 0", BVALID, RVALID);
    end
    checks++;
    if (reg_out !== flat()) begin
      failures++;
      $display("FAIL rm_regs: got %h want %h", reg_out, flat());
    end
    #10 ARESETN = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111 || BVALID !== 1'b0) begin
      failures++;
      $display("FAIL rm_after: aw/w/ar=%b%b%b bv=%b want 111 0",
               AWREADY, WREADY, ARREADY, BVALID);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    #22 ARESETN = 1'b1;
    tick();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_strobe();
    test_out_of_range();
    test_b_backpressure();
    test_r_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
